// File: rtl/ysyx_22050019_lsu.sv
// ysyx_22050019_lsu: MEM-stage load/store unit with a valid/ready request bus and a single-beat response.
// Optional macro YSYX_22050019_LSU_MISALIGN_CHECK_EN traps misaligned accesses instead of issuing them.
module ysyx_22050019_lsu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] pc_i,
  input  logic [31:0] inst_i,
  input  logic        commite_i,
  input  logic        reg_we_i,
  input  logic [4:0]  reg_waddr_i,
  input  logic [63:0] alu_result_i,
  input  logic        mem_ren_i,
  input  logic        mem_wen_i,
  input  logic [1:0]  mem_size_i,
  input  logic        mem_unsigned_i,
  input  logic [63:0] store_data_i,
  output logic        req_valid_o,
  input  logic        req_ready_i,
  output logic [63:0] req_addr_o,
  output logic        req_wen_o,
  output logic [63:0] req_wdata_o,
  output logic [7:0]  req_wstrb_o,
  input  logic        resp_valid_i,
  input  logic [63:0] resp_rdata_i,
  output logic [63:0] pc_o,
  output logic [31:0] inst_o,
  output logic        commite_o,
  output logic        reg_we_wbu_o,
  output logic [4:0]  reg_waddr_wbu_o,
  output logic [63:0] reg_wdata_wbu_o,
  output logic        mem_stall_o,
  output logic        misalign_o
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t      state;
  logic [63:0] rdata;
  logic        req_valid;
  logic        mem_op;
  logic        skip;
  logic        start;
  logic [2:0]  offset;
  logic [7:0]  size_mask;
  logic [63:0] shifted;
  logic [63:0] load_data;

  assign mem_op = mem_ren_i | mem_wen_i;
  assign offset = alu_result_i[2:0];

`ifdef YSYX_22050019_LSU_MISALIGN_CHECK_EN
  logic misaligned;

  always_comb begin
    case (mem_size_i)
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = offset[0];
      2'd2:    misaligned = |offset[1:0];
      default: misaligned = |offset;
    endcase
  end

  assign skip = mem_op & misaligned;
`else
  assign skip = 1'b0;
`endif

  assign start = (state == IDLE) & mem_op & ~skip;

  // Request fields come straight from the held upstream inputs; only state, valid and rdata are stored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rdata     <= 64'd0;
      req_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state     <= REQ;
            req_valid <= 1'b1;
          end
        end
        REQ: begin
          if (req_ready_i) begin
            state     <= WAIT;
            req_valid <= 1'b0;
          end
        end
        WAIT: begin
          if (resp_valid_i) begin
            rdata <= resp_rdata_i;
            state <= DONE;
          end
        end
        default: begin
          state     <= IDLE;
          req_valid <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    case (mem_size_i)
      2'd0:    size_mask = 8'h01;
      2'd1:    size_mask = 8'h03;
      2'd2:    size_mask = 8'h0F;
      default: size_mask = 8'hFF;
    endcase
  end

  assign req_valid_o = req_valid;
  assign req_addr_o  = {alu_result_i[63:3], 3'b000};
  assign req_wen_o   = mem_wen_i;
  assign req_wstrb_o = size_mask << offset;
  assign req_wdata_o = store_data_i << {offset, 3'b000};

  assign shifted = rdata >> {offset, 3'b000};

  always_comb begin
    case (mem_size_i)
      2'd0:    load_data = mem_unsigned_i ? {56'd0, shifted[7:0]}  : {{56{shifted[7]}}, shifted[7:0]};
      2'd1:    load_data = mem_unsigned_i ? {48'd0, shifted[15:0]} : {{48{shifted[15]}}, shifted[15:0]};
      2'd2:    load_data = mem_unsigned_i ? {32'd0, shifted[31:0]} : {{32{shifted[31]}}, shifted[31:0]};
      default: load_data = shifted;
    endcase
  end

  // Stall drops in DONE so the finished instruction commits exactly once.
  assign mem_stall_o = start | (state == REQ) | (state == WAIT);
  assign misalign_o  = rst_n & (state == IDLE) & skip;
  assign commite_o   = rst_n & commite_i & ~mem_stall_o;

  assign pc_o            = pc_i;
  assign inst_o          = inst_i;
  assign reg_waddr_wbu_o = reg_waddr_i;
  assign reg_we_wbu_o    = reg_we_i & ~misalign_o;

  always_comb begin
    reg_wdata_wbu_o = alu_result_i;
    if (state == DONE) begin
      reg_wdata_wbu_o = mem_wen_i ? 64'd0 : load_data;
    end
  end

endmodule

// File: tb/tb_ysyx_22050019_lsu.sv
// Scoreboard bench for ysyx_22050019_lsu: directed vectors push expected bus requests and writebacks,
// a negedge monitor pops and compares them whenever the DUT handshakes a request or commits.
module tb_ysyx_22050019_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] pc_i;
  logic [31:0] inst_i;
  logic        commite_i;
  logic        reg_we_i;
  logic [4:0]  reg_waddr_i;
  logic [63:0] alu_result_i;
  logic        mem_ren_i;
  logic        mem_wen_i;
  logic [1:0]  mem_size_i;
  logic        mem_unsigned_i;
  logic [63:0] store_data_i;
  logic        req_valid_o;
  logic        req_ready_i;
  logic [63:0] req_addr_o;
  logic        req_wen_o;
  logic [63:0] req_wdata_o;
  logic [7:0]  req_wstrb_o;
  logic        resp_valid_i;
  logic [63:0] resp_rdata_i;
  logic [63:0] pc_o;
  logic [31:0] inst_o;
  logic        commite_o;
  logic        reg_we_wbu_o;
  logic [4:0]  reg_waddr_wbu_o;
  logic [63:0] reg_wdata_wbu_o;
  logic        mem_stall_o;
  logic        misalign_o;

  localparam logic [63:0] DECOY = 64'hDEAD_DEAD_DEAD_DEAD;

  always #5 clk = ~clk;

  ysyx_22050019_lsu dut (
    .clk(clk), .rst_n(rst_n),
    .pc_i(pc_i), .inst_i(inst_i), .commite_i(commite_i),
    .reg_we_i(reg_we_i), .reg_waddr_i(reg_waddr_i), .alu_result_i(alu_result_i),
    .mem_ren_i(mem_ren_i), .mem_wen_i(mem_wen_i), .mem_size_i(mem_size_i),
    .mem_unsigned_i(mem_unsigned_i), .store_data_i(store_data_i),
    .req_valid_o(req_valid_o), .req_ready_i(req_ready_i), .req_addr_o(req_addr_o),
    .req_wen_o(req_wen_o), .req_wdata_o(req_wdata_o), .req_wstrb_o(req_wstrb_o),
    .resp_valid_i(resp_valid_i), .resp_rdata_i(resp_rdata_i),
    .pc_o(pc_o), .inst_o(inst_o), .commite_o(commite_o),
    .reg_we_wbu_o(reg_we_wbu_o), .reg_waddr_wbu_o(reg_waddr_wbu_o),
    .reg_wdata_wbu_o(reg_wdata_wbu_o), .mem_stall_o(mem_stall_o), .misalign_o(misalign_o)
  );

  typedef struct packed {
    logic [63:0] addr;
    logic        wen;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
  } req_exp_t;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
    logic        we;
    logic [4:0]  waddr;
    logic [63:0] wdata;
    logic        chk_data;
    logic        misalign;
    logic [7:0]  stalls;
  } wb_exp_t;

  req_exp_t req_q[$];
  wb_exp_t  wb_q[$];
  int       checks = 0;
  int       passes = 0;
  int       stall_cnt = 0;
  req_exp_t req_e;
  wb_exp_t  wb_e;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Monitor: compares every request handshake and every commit against the scoreboard queues.
  always @(negedge clk) begin
    if (req_valid_o && req_ready_i) begin
      if (req_q.size() == 0) begin
        checks++;
        $display("[TB] FAIL unexpected_request: got addr 0x%0h, expected no request", req_addr_o);
      end else begin
        req_e = req_q.pop_front();
        checkOutput("req_addr", req_addr_o, req_e.addr);
        checkOutput("req_wen", 64'(req_wen_o), 64'(req_e.wen));
        checkOutput("req_wdata", req_wdata_o, req_e.wdata);
        checkOutput("req_wstrb", 64'(req_wstrb_o), 64'(req_e.wstrb));
      end
    end
    if (commite_o) begin
      if (wb_q.size() == 0) begin
        checks++;
        $display("[TB] FAIL unexpected_commit: got commit pc 0x%0h, expected none", pc_o);
      end else begin
        wb_e = wb_q.pop_front();
        checkOutput("wb_pc", pc_o, wb_e.pc);
        checkOutput("wb_inst", 64'(inst_o), 64'(wb_e.inst));
        checkOutput("wb_we", 64'(reg_we_wbu_o), 64'(wb_e.we));
        checkOutput("wb_waddr", 64'(reg_waddr_wbu_o), 64'(wb_e.waddr));
        if (wb_e.chk_data) checkOutput("wb_wdata", reg_wdata_wbu_o, wb_e.wdata);
        checkOutput("wb_misalign", 64'(misalign_o), 64'(wb_e.misalign));
        checkOutput("wb_stall_cycles", 64'(stall_cnt), 64'(wb_e.stalls));
      end
      stall_cnt = 0;
    end else if (rst_n && mem_stall_o) begin
      stall_cnt++;
    end else begin
      stall_cnt = 0;
    end
  end

  // Drives one instruction and walks it through REQ/WAIT with the given ready/response delays.
  // resp_valid_i carries decoy data in every cycle where the DUT must ignore it.
  task automatic applyStimulus(
    input logic [63:0] pc, input logic [31:0] inst, input logic commit, input logic we,
    input logic [4:0] waddr, input logic [63:0] alu, input logic ren, input logic wen,
    input logic [1:0] size, input logic uns, input logic [63:0] sdata,
    input int rd, input int rs, input logic [63:0] rdata,
    input logic [63:0] exp_wdata, input logic [7:0] exp_strb, input logic [63:0] exp_reqdata,
    input logic [7:0] stalls, input logic skip);
    wb_exp_t  w;
    req_exp_t r;
    pc_i = pc; inst_i = inst; commite_i = commit; reg_we_i = we; reg_waddr_i = waddr;
    alu_result_i = alu; mem_ren_i = ren; mem_wen_i = wen; mem_size_i = size;
    mem_unsigned_i = uns; store_data_i = sdata;
    req_ready_i = 1'b0; resp_valid_i = 1'b1; resp_rdata_i = DECOY;
    w.pc = pc; w.inst = inst; w.we = skip ? 1'b0 : we; w.waddr = waddr; w.wdata = exp_wdata;
    w.chk_data = ~skip; w.misalign = skip; w.stalls = (ren | wen) && !skip ? stalls : 8'd0;
    if (commit) wb_q.push_back(w);
    if ((ren || wen) && !skip) begin
      r.addr = {alu[63:3], 3'b000}; r.wen = wen; r.wdata = exp_reqdata; r.wstrb = exp_strb;
      req_q.push_back(r);
      @(posedge clk); #1;
      for (int i = 1; i <= rd; i++) begin
        req_ready_i = (i == rd);
        @(posedge clk); #1;
      end
      req_ready_i = 1'b0;
      for (int i = 1; i <= rs; i++) begin
        resp_valid_i = (i == rs);
        resp_rdata_i = (i == rs) ? rdata : DECOY;
        @(posedge clk); #1;
      end
      resp_valid_i = 1'b1; resp_rdata_i = DECOY;
    end
    @(posedge clk); #1;
  endtask

  logic lw_skip;

  initial begin
`ifdef YSYX_22050019_LSU_MISALIGN_CHECK_EN
    lw_skip = 1'b1;
`else
    lw_skip = 1'b0;
`endif
    rst_n = 1'b0;
    pc_i = 64'h8000_0000; inst_i = 32'h13; commite_i = 1'b1; reg_we_i = 1'b1; reg_waddr_i = 5'd1;
    alu_result_i = 64'h55; mem_ren_i = 1'b0; mem_wen_i = 1'b0; mem_size_i = 2'd0;
    mem_unsigned_i = 1'b0; store_data_i = 64'd0; req_ready_i = 1'b0;
    resp_valid_i = 1'b0; resp_rdata_i = 64'd0;
    #3;
    checkOutput("rst_commite", 64'(commite_o), 64'd0);
    checkOutput("rst_req_valid", 64'(req_valid_o), 64'd0);
    checkOutput("rst_stall", 64'(mem_stall_o), 64'd0);
    checkOutput("rst_misalign", 64'(misalign_o), 64'd0);
    checkOutput("rst_wdata_passthru", reg_wdata_wbu_o, 64'h55);
    checkOutput("rst_rdata", dut.rdata, 64'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // pc, inst, commit, we, waddr, alu, ren, wen, size, uns, sdata, rd, rs, rdata, exp_wdata, exp_strb, exp_reqdata, stalls, skip
    applyStimulus(64'h8000_0000, 32'h00b5_0533, 1, 1, 5'd10, 64'h42, 0, 0, 2'd0, 0, 64'd0, 0, 0, 64'd0, 64'h42, 8'h00, 64'd0, 8'd0, 0);
    applyStimulus(64'h8000_0004, 32'h0085_3283, 1, 1, 5'd5, 64'h8000_0008, 1, 0, 2'd3, 0, 64'd0, 2, 1, 64'h1122_3344_5566_7788, 64'h1122_3344_5566_7788, 8'hFF, 64'd0, 8'd4, 0);
    applyStimulus(64'h8000_0008, 32'h0030_0283, 1, 1, 5'd6, 64'h8000_0003, 1, 0, 2'd0, 0, 64'd0, 1, 1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FF80, 8'h08, 64'd0, 8'd3, 0);
    applyStimulus(64'h8000_000C, 32'h0030_4283, 1, 1, 5'd7, 64'h8000_0003, 1, 0, 2'd0, 1, 64'd0, 1, 2, 64'h0000_0000_8000_0000, 64'h0000_0000_0000_0080, 8'h08, 64'd0, 8'd4, 0);
    applyStimulus(64'h8000_0010, 32'h0081_1323, 1, 0, 5'd0, 64'h8000_0006, 0, 1, 2'd1, 0, 64'hBEEF, 1, 1, 64'h5555_5555_5555_5555, 64'd0, 8'hC0, 64'hBEEF_0000_0000_0000, 8'd3, 0);
    applyStimulus(64'h8000_0014, 32'h0000_0013, 0, 1, 5'd3, 64'h7, 0, 0, 2'd0, 0, 64'd0, 0, 0, 64'd0, 64'h7, 8'h00, 64'd0, 8'd0, 0);
    applyStimulus(64'h8000_0018, 32'h0142_a283, 1, 1, 5'd8, 64'h8000_0014, 1, 0, 2'd2, 0, 64'd0, 3, 1, 64'h89AB_CDEF_0000_0000, 64'hFFFF_FFFF_89AB_CDEF, 8'hF0, 64'd0, 8'd5, 0);
    applyStimulus(64'h8000_001C, 32'h0142_e283, 1, 1, 5'd9, 64'h8000_0014, 1, 0, 2'd2, 1, 64'd0, 1, 1, 64'h89AB_CDEF_0000_0000, 64'h0000_0000_89AB_CDEF, 8'hF0, 64'd0, 8'd3, 0);
    applyStimulus(64'h8000_0020, 32'h0021_1283, 1, 1, 5'd11, 64'h8000_0002, 1, 0, 2'd1, 0, 64'd0, 1, 1, 64'h0000_0000_F00D_0000, 64'hFFFF_FFFF_FFFF_F00D, 8'h0C, 64'd0, 8'd3, 0);
    applyStimulus(64'h8000_0024, 32'h00a0_00a3, 1, 0, 5'd0, 64'h8000_0001, 1, 1, 2'd0, 0, 64'hAA, 1, 1, 64'd0, 64'd0, 8'h02, 64'h0000_0000_0000_AA00, 8'd3, 0);
    applyStimulus(64'h8000_0028, 32'h00a1_3c23, 1, 0, 5'd0, 64'h8000_0018, 0, 1, 2'd3, 0, 64'h0123_4567_89AB_CDEF, 2, 2, 64'd0, 64'd0, 8'hFF, 64'h0123_4567_89AB_CDEF, 8'd5, 0);
    applyStimulus(64'h8000_002C, 32'h0021_2283, 1, 1, 5'd12, 64'h8000_0002, 1, 0, 2'd2, 0, 64'd0, 1, 1, 64'h0000_DEAD_BEEF_0000, 64'hFFFF_FFFF_DEAD_BEEF, 8'h3C, 64'd0, 8'd3, lw_skip);
    applyStimulus(64'h8000_0030, 32'h0020_3283, 1, 1, 5'd13, 64'h8000_0020, 1, 0, 2'd3, 1, 64'd0, 1, 1, 64'h8000_0000_0000_0001, 64'h8000_0000_0000_0001, 8'hFF, 64'd0, 8'd3, 0);
    applyStimulus(64'h8000_0034, 32'h0000_0533, 1, 1, 5'd14, 64'h1234, 0, 0, 2'd0, 0, 64'd0, 0, 0, 64'd0, 64'h1234, 8'h00, 64'd0, 8'd0, 0);

    // Abandon an LD in WAIT with an async reset, then offer a stray response after release.
    pc_i = 64'h8000_0038; inst_i = 32'h0003_3283; commite_i = 1'b1; reg_we_i = 1'b1; reg_waddr_i = 5'd15;
    alu_result_i = 64'h8000_0030; mem_ren_i = 1'b1; mem_wen_i = 1'b0; mem_size_i = 2'd3;
    mem_unsigned_i = 1'b0; store_data_i = 64'd0; resp_valid_i = 1'b0;
    req_q.push_back('{addr: 64'h8000_0030, wen: 1'b0, wdata: 64'd0, wstrb: 8'hFF});
    @(posedge clk); #1;
    req_ready_i = 1'b1;
    @(posedge clk); #1;
    req_ready_i = 1'b0;
    #2;
    rst_n = 1'b0;
    mem_ren_i = 1'b0; alu_result_i = 64'h99;
    #1;
    checkOutput("midrst_commite", 64'(commite_o), 64'd0);
    checkOutput("midrst_stall", 64'(mem_stall_o), 64'd0);
    checkOutput("midrst_req_valid", 64'(req_valid_o), 64'd0);
    checkOutput("midrst_rdata", dut.rdata, 64'd0);
    checkOutput("midrst_wdata_passthru", reg_wdata_wbu_o, 64'h99);
    @(posedge clk); #1;
    commite_i = 1'b0;
    rst_n = 1'b1;
    resp_valid_i = 1'b1; resp_rdata_i = 64'hFEED_FACE_FEED_FACE;
    @(posedge clk); #1;
    resp_valid_i = 1'b0;
    checkOutput("stray_resp_rdata", dut.rdata, 64'd0);
    checkOutput("stray_resp_stall", 64'(mem_stall_o), 64'd0);
    checkOutput("stray_resp_req_valid", 64'(req_valid_o), 64'd0);
    @(posedge clk); #1;

    applyStimulus(64'h8000_003C, 32'h0000_4283, 1, 1, 5'd16, 64'h8000_0040, 1, 0, 2'd0, 1, 64'd0, 1, 1, 64'h0000_0000_0000_007F, 64'h7F, 8'h01, 64'd0, 8'd3, 0);

    commite_i = 1'b0; mem_ren_i = 1'b0; mem_wen_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("req_queue_drained", 64'(req_q.size()), 64'd0);
    checkOutput("wb_queue_drained", 64'(wb_q.size()), 64'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
